mem_port_arbiter: RTL and testbench

- Shares one single-ported, synchronous-read unified memory between instruction fetch (IF) and load/store data (DM) in the RISCV32I core.
- Sits between the fetch/PC logic and the control-unit-driven MemRead/MemWrite path on one side, and the unified memory macro on the other.
- Grants one access per cycle, routes read data back to the owner, and raises a pipeline stall when a requester is not granted.
- Data has priority over fetch; a starvation guard prevents indefinite fetch blocking.

---
 rtl/mem_port_arbiter.sv | 104 ++++++++++
 tb/tb_mem_port_arbiter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported, synchronous-read memory between instruction fetch and data access.
// Build option: define ARB_STATS_EN to enable the 16-bit saturating conflict_cnt statistic.
module mem_port_arbiter #(
    parameter int ADDR_W     = 12,
    parameter int STARVE_LIM = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [3:0]        dm_be,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [31:0]       dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [31:0]       dm_rdata,
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              stall,
    output logic [15:0]       conflict_cnt
);

    typedef enum logic [1:0] {IDLE, RD_IF, RD_DM} state_t;

    state_t     r_state;
    logic [3:0] r_starve_cnt;
    logic       w_if_win;
    logic       w_dm_win;

    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        w_if_win = 1'b0;
        w_dm_win = 1'b0;
        if (!rst) begin
            if (r_starve_cnt == 4'(STARVE_LIM) && if_req) w_if_win = 1'b1;
            else if (dm_req)                              w_dm_win = 1'b1;
            else if (if_req)                              w_if_win = 1'b1;
        end
    end

    assign if_gnt = w_if_win;
    assign dm_gnt = w_dm_win;
    assign stall  = !rst && ((if_req && !w_if_win) || (dm_req && !w_dm_win));

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 4'b0000;
        mem_addr  = '0;
        mem_wdata = 32'h0;
        if (w_if_win) begin
            mem_en    = 1'b1;
            mem_addr  = if_addr;
            mem_wdata = dm_wdata;
        end else if (w_dm_win) begin
            mem_en    = 1'b1;
            mem_we    = dm_we ? dm_be : 4'b0000;
            mem_addr  = dm_addr;
            mem_wdata = dm_wdata;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_starve_cnt <= 4'd0;
        end else begin
            if (w_if_win)                r_state <= RD_IF;
            else if (w_dm_win && !dm_we) r_state <= RD_DM;
            else                         r_state <= IDLE;

            if (!if_req || w_if_win)                r_starve_cnt <= 4'd0;
            else if (r_starve_cnt < 4'(STARVE_LIM)) r_starve_cnt <= r_starve_cnt + 4'd1;
        end
    end

    // Gated by rst so a read outstanding when reset arrives never reports valid data.
    assign if_rvalid = !rst && (r_state == RD_IF);
    assign dm_rvalid = !rst && (r_state == RD_DM);
    assign if_rdata  = if_rvalid ? mem_rdata : 32'h0;
    assign dm_rdata  = dm_rvalid ? mem_rdata : 32'h0;

`ifdef ARB_STATS_EN
    logic [15:0] r_conflict_cnt;

    always_ff @(posedge clk) begin
        if (rst)                                        r_conflict_cnt <= 16'h0000;
        else if (if_req && dm_req && r_conflict_cnt != 16'hFFFF) r_conflict_cnt <= r_conflict_cnt + 16'd1;
    end

    assign conflict_cnt = rst ? 16'h0000 : r_conflict_cnt;
`else
    assign conflict_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a behavioural synchronous-read memory.
// Expected conflict_cnt follows the ARB_STATS_EN build option.
module tb_mem_port_arbiter;

    localparam int ADDR_W = 12;

    logic              clk = 1'b0;
    logic              rst;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [31:0]       if_rdata;
    logic              dm_req;
    logic              dm_we;
    logic [3:0]        dm_be;
    logic [ADDR_W-1:0] dm_addr;
    logic [31:0]       dm_wdata;
    logic              dm_gnt;
    logic              dm_rvalid;
    logic [31:0]       dm_rdata;
    logic              mem_en;
    logic [3:0]        mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              stall;
    logic [15:0]       conflict_cnt;

    logic [31:0] mem [0:(1<<ADDR_W)-1];
    int n_checks = 0;
    int n_pass   = 0;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .STARVE_LIM(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .stall(stall), .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pat(input int a);
        return 32'hC0DE_0000 | 32'(a);
    endfunction

    always @(posedge clk) begin
        if (mem_en) begin
            for (int b = 0; b < 4; b++)
                if (mem_we[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            if (mem_we == 4'b0000) mem_rdata <= mem[mem_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
        else             n_pass++;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] exp_conf;
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = pat(i);
        mem_rdata = 32'h0;
        rst = 1'b1; if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0;
        dm_be = 4'b0000; dm_addr = '0; dm_wdata = 32'h0;
        cycle();
        if_req = 1'b1; dm_req = 1'b1;
        #1;
        check("rst_if_gnt", 32'(if_gnt), 32'd0);
        check("rst_dm_gnt", 32'(dm_gnt), 32'd0);
        check("rst_stall",  32'(stall),  32'd0);
        check("rst_mem_en", 32'(mem_en), 32'd0);
        check("rst_conf",   32'(conflict_cnt), 32'd0);
        cycle();

        // Reset mid-read
        rst = 1'b0; dm_req = 1'b0; if_req = 1'b1; if_addr = 12'h010;
        #1;
        check("mid_if_gnt",   32'(if_gnt),   32'd1);
        check("mid_mem_addr", 32'(mem_addr), 32'h010);
        cycle();
        rst = 1'b1;
        #1;
        check("mid_rvalid",  32'(if_rvalid), 32'd0);
        check("mid_rdata",   if_rdata,       32'h0);
        check("mid_if_gnt0", 32'(if_gnt),    32'd0);
        check("mid_stall",   32'(stall),     32'd0);
        check("mid_mem_en",  32'(mem_en),    32'd0);
        cycle();
        rst = 1'b0; if_req = 1'b0;
        #1;
        check("mid_rvalid_after", 32'(if_rvalid), 32'd0);

        // IF only stream
        for (int i = 0; i < 3; i++) begin
            if_req = 1'b1; if_addr = 12'(i);
            #1;
            check("ifs_gnt",   32'(if_gnt),   32'd1);
            check("ifs_stall", 32'(stall),    32'd0);
            check("ifs_addr",  32'(mem_addr), 32'(i));
            if (i > 0) begin
                check("ifs_rvalid", 32'(if_rvalid), 32'd1);
                check("ifs_rdata",  if_rdata,       pat(i - 1));
            end
            cycle();
        end
        if_req = 1'b0;
        #1;
        check("ifs_rvalid_last", 32'(if_rvalid), 32'd1);
        check("ifs_rdata_last",  if_rdata,       pat(2));
        cycle();

        // Collision: DM load wins, IF served next cycle
        if_req = 1'b1; if_addr = 12'h020; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 12'h100;
        #1;
        check("col_dm_gnt", 32'(dm_gnt),   32'd1);
        check("col_if_gnt", 32'(if_gnt),   32'd0);
        check("col_stall",  32'(stall),    32'd1);
        check("col_addr",   32'(mem_addr), 32'h100);
        cycle();
        dm_req = 1'b0;
        #1;
        check("col_dm_rvalid", 32'(dm_rvalid), 32'd1);
        check("col_dm_rdata",  dm_rdata,       pat(12'h100));
        check("col_if_rvalid", 32'(if_rvalid), 32'd0);
        check("col_if_gnt2",   32'(if_gnt),    32'd1);
        check("col_addr2",     32'(mem_addr),  32'h020);
        cycle();
        if_req = 1'b0;
        #1;
        check("col_if_rvalid2", 32'(if_rvalid), 32'd1);
        check("col_if_rdata",   if_rdata,       pat(12'h020));
        check("col_dm_rvalid2", 32'(dm_rvalid), 32'd0);
        cycle();

        // Store with partial byte enables, then load it back
        dm_req = 1'b1; dm_we = 1'b1; dm_be = 4'b0011; dm_wdata = 32'hDEAD_BEEF; dm_addr = 12'h004;
        #1;
        check("st_gnt",    32'(dm_gnt),    32'd1);
        check("st_mem_en", 32'(mem_en),    32'd1);
        check("st_mem_we", 32'(mem_we),    32'b0011);
        check("st_wdata",  mem_wdata,      32'hDEAD_BEEF);
        cycle();
        dm_req = 1'b0; dm_we = 1'b0; dm_be = 4'b0000;
        #1;
        check("st_rvalid1", 32'(dm_rvalid), 32'd0);
        cycle();
        check("st_rvalid2", 32'(dm_rvalid), 32'd0);
        dm_req = 1'b1;
        #1;
        check("ld_mem_we", 32'(mem_we), 32'd0);
        cycle();
        dm_req = 1'b0;
        #1;
        check("ld_rdata", dm_rdata, 32'hC0DE_BEEF);
        cycle();

        // Starvation guard: IF wins on cycles 5 and 10 while both request
        if_req = 1'b1; if_addr = 12'h030; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 12'h200;
        for (int c = 1; c <= 10; c++) begin
            #1;
            check($sformatf("stv_if_gnt_c%0d", c), 32'(if_gnt), 32'((c % 5) == 0));
            check($sformatf("stv_dm_gnt_c%0d", c), 32'(dm_gnt), 32'((c % 5) != 0));
            cycle();
        end
        if_req = 1'b0; dm_req = 1'b0;
        #1;
        check("stv_if_rvalid", 32'(if_rvalid), 32'd1);
        check("stv_if_rdata",  if_rdata,       pat(12'h030));
        cycle();

        // Contention statistic over exactly 7 collision cycles after a fresh reset
        rst = 1'b1;
        cycle();
        rst = 1'b0; if_req = 1'b1; dm_req = 1'b1;
        repeat (7) cycle();
        if_req = 1'b0; dm_req = 1'b0;
`ifdef ARB_STATS_EN
        exp_conf = 16'd7;
`else
        exp_conf = 16'd0;
`endif
        #1;
        check("conf_cnt", 32'(conflict_cnt), 32'(exp_conf));
        cycle();
        check("conf_hold", 32'(conflict_cnt), 32'(exp_conf));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
